// File: rtl/apb_pkg.sv
// Shared types and constants for the APB subsystem: one bridge (master FSM)
// and two identical word-addressed memory slaves.
package apb_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int ADDR_WIDTH   = 9;
  localparam int MEM_DEPTH    = 64;

  // Low address bits form the word offset inside a slave; the MSB selects the slave.
  localparam int OFFSET_WIDTH = ADDR_WIDTH - 1;
  localparam int INDEX_WIDTH  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // True when a word offset addresses a physically present location.
  function automatic logic offset_in_range(input logic [OFFSET_WIDTH-1:0] offset);
    return offset < OFFSET_WIDTH'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/apb_slave.sv
// Zero-wait-state APB memory slave, MEM_DEPTH x DATA_WIDTH words.
// With APB_SLVERR_CHECK_EN defined, offsets >= MEM_DEPTH raise PSLVERR, writes
// to them are dropped and reads return 0. Without it, offsets wrap modulo
// MEM_DEPTH and every transfer completes normally.
module apb_slave
  import apb_pkg::*;
(
  input  logic                    PCLK,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [OFFSET_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
  logic [INDEX_WIDTH-1:0] index;
  logic                   addr_err;

  assign index = PADDR[INDEX_WIDTH-1:0];

`ifdef APB_SLVERR_CHECK_EN
  assign addr_err = !offset_in_range(PADDR);
`else
  // Upper offset bits are ignored: addresses alias onto the physical words.
  logic unused_offset_hi;
  assign unused_offset_hi = ^PADDR[OFFSET_WIDTH-1:INDEX_WIDTH];
  assign addr_err         = 1'b0;
`endif

  assign PREADY  = PSEL & PENABLE;
  assign PSLVERR = PREADY & addr_err;
  assign PRDATA  = addr_err ? '0 : mem[index];

  // Memory write in the ACCESS cycle of an in-range write.
  // NOTE: the storage array has no reset on purpose: contents must survive a
  // bus reset, and a reset would also stop the array mapping onto RAM.
  always_ff @(posedge PCLK) begin
    if (PREADY && PWRITE && !addr_err) begin
      mem[index] <= PWDATA;
    end
  end

endmodule

// File: rtl/apb.sv
// APB subsystem top: local-side request -> APB master FSM (IDLE/SETUP/ACCESS)
// driving two apb_slave instances selected by address bit ADDR_WIDTH-1.
// Optional out-of-range error reporting is enabled by APB_SLVERR_CHECK_EN.
// PRESETn is a synchronous, active-high reset despite its name.
module apb
  import apb_pkg::*;
(
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH-1:0] apb_write_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [ADDR_WIDTH-1:0] apb_read_paddr,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] apb_read_data_out
);

  apb_state_e            state, next_state;

  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;

  logic                  psel0, psel1, penable;
  logic                  slave_pwrite;
  logic                  pready0, pready1, pready;
  logic                  pslverr0, pslverr1, pslverr_sel;
  logic [DATA_WIDTH-1:0] prdata0, prdata1, prdata;
  logic                  slave_sel;

  assign slave_sel = paddr[ADDR_WIDTH-1];

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge PCLK) begin
    if (PRESETn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (transfer) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready) next_state = transfer ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus control outputs decoded from the current state.
  always_comb begin
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    unique case (state)
      SETUP: begin
        psel0 = ~slave_sel;
        psel1 = slave_sel;
      end
      ACCESS: begin
        psel0   = ~slave_sel;
        psel1   = slave_sel;
        penable = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the request on the edge that enters SETUP; held through ACCESS.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (next_state == SETUP) begin
      pwrite <= ~READ_WRITE;
      paddr  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
      pwdata <= apb_write_data;
    end
  end

  // A write whose ACCESS edge coincides with reset is suppressed: reset wins.
  assign slave_pwrite = pwrite & ~PRESETn;

  apb_slave u_slave0 (
    .PCLK    (PCLK),
    .PSEL    (psel0),
    .PENABLE (penable),
    .PWRITE  (slave_pwrite),
    .PADDR   (paddr[OFFSET_WIDTH-1:0]),
    .PWDATA  (pwdata),
    .PREADY  (pready0),
    .PRDATA  (prdata0),
    .PSLVERR (pslverr0)
  );

  apb_slave u_slave1 (
    .PCLK    (PCLK),
    .PSEL    (psel1),
    .PENABLE (penable),
    .PWRITE  (slave_pwrite),
    .PADDR   (paddr[OFFSET_WIDTH-1:0]),
    .PWDATA  (pwdata),
    .PREADY  (pready1),
    .PRDATA  (prdata1),
    .PSLVERR (pslverr1)
  );

  // Response mux driven by the latched slave-select bit.
  assign pready      = slave_sel ? pready1  : pready0;
  assign prdata      = slave_sel ? prdata1  : prdata0;
  assign pslverr_sel = slave_sel ? pslverr1 : pslverr0;

  assign PSLVERR = (state == ACCESS) & pslverr_sel;

  // Read data register: loads at the end of a completed read ACCESS.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      apb_read_data_out <= '0;
    end else if (state == ACCESS && pready && !pwrite) begin
      apb_read_data_out <= prdata;
    end
  end

endmodule

// File: tb/tb_apb.sv
// Self-checking bench for apb: directed tables plus randomized transfers
// checked against a transaction-level memory model.
module tb_apb;
  import apb_pkg::*;

`ifdef APB_SLVERR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic       rw;       // 1 = read
    logic [8:0] addr;
    logic [7:0] data;
    logic       chk;      // 1 = use the constant expectations below
    logic       exp_err;
    logic [7:0] exp_rd;
  } txn_t;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       transfer;
  logic       READ_WRITE;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic       PSLVERR;
  logic [7:0] apb_read_data_out;

  apb dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .PSLVERR           (PSLVERR),
    .apb_read_data_out (apb_read_data_out)
  );

  always #5 PCLK = ~PCLK;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] m [2][MEM_DEPTH];
  logic [7:0] exp_rd;
  txn_t       pend [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mdl_err(input logic [7:0] off);
    return CHECK_EN && (int'(off) >= MEM_DEPTH);
  endfunction

  function automatic int mdl_idx(input logic [7:0] off);
    return int'(off) % MEM_DEPTH;
  endfunction

  function automatic txn_t mk(input logic rw, input logic [8:0] a, input logic [7:0] d,
                              input logic chk, input logic e, input logic [7:0] r);
    txn_t t;
    t.rw = rw; t.addr = a; t.data = d; t.chk = chk; t.exp_err = e; t.exp_rd = r;
    return t;
  endfunction

  task automatic set_txn(input txn_t t);
    READ_WRITE = t.rw;
    if (t.rw) begin
      apb_read_paddr  = t.addr;
      apb_write_paddr = 9'($urandom);
    end else begin
      apb_write_paddr = t.addr;
      apb_read_paddr  = 9'($urandom);
    end
    apb_write_data = t.data;
    transfer       = 1'b1;
  endtask

  task automatic scramble(input logic tr);
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = 9'($urandom);
    apb_read_paddr  = 9'($urandom);
    apb_write_data  = 8'($urandom);
    transfer        = tr;
  endtask

  // Issue everything in pend back-to-back, then drop transfer after the last ACCESS.
  task automatic run();
    logic e;
    int   sel, idx;
    if (pend.size() == 0) return;
    set_txn(pend[0]);
    for (int i = 0; i < pend.size(); i++) begin
      @(posedge PCLK); #1;
      if (i > 0) check("rdata", apb_read_data_out, exp_rd);
      check("setup_pslverr", {7'd0, PSLVERR}, 8'd0);
      scramble(1'($urandom));
      @(posedge PCLK); #1;
      e   = mdl_err(pend[i].addr[7:0]);
      sel = int'(pend[i].addr[8]);
      idx = mdl_idx(pend[i].addr[7:0]);
      check("access_pslverr", {7'd0, PSLVERR}, {7'd0, pend[i].chk ? pend[i].exp_err : e});
      if (pend[i].rw) exp_rd = pend[i].chk ? pend[i].exp_rd : (e ? 8'h00 : m[sel][idx]);
      else if (!e)    m[sel][idx] = pend[i].data;
      if (i + 1 < pend.size()) set_txn(pend[i + 1]);
      else                     scramble(1'b0);
    end
    @(posedge PCLK); #1;
    check("rdata_last", apb_read_data_out, exp_rd);
    check("idle_pslverr", {7'd0, PSLVERR}, 8'd0);
    pend.delete();
  endtask

  // Idle with transfer low while presenting a write that must never happen.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      READ_WRITE      = 1'b0;
      apb_write_paddr = {1'b1, 8'd0};
      apb_write_data  = ~m[1][0];
      apb_read_paddr  = 9'($urandom);
      transfer        = 1'b0;
      @(posedge PCLK); #1;
      check("idle_pslverr", {7'd0, PSLVERR}, 8'd0);
      check("idle_rdata", apb_read_data_out, exp_rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tbl_wr [4];
    txn_t tbl_rd [7];
    logic [8:0] a;
    int n;

    tbl_wr[0] = mk(1'b0, {1'b1, 8'd60}, 8'hD9, 1'b1, 1'b0, 8'h00);
    tbl_wr[1] = mk(1'b0, {1'b1, 8'd54}, 8'h9D, 1'b1, 1'b0, 8'h00);
    tbl_wr[2] = mk(1'b0, {1'b0, 8'd12}, 8'hF9, 1'b1, 1'b0, 8'h00);
    tbl_wr[3] = mk(1'b0, {1'b0, 8'd63}, 8'hBB, 1'b1, 1'b0, 8'h00);
    tbl_rd[0] = mk(1'b1, {1'b1, 8'd60}, 8'h00, 1'b1, 1'b0, 8'hD9);
    tbl_rd[1] = mk(1'b1, {1'b1, 8'd54}, 8'h00, 1'b1, 1'b0, 8'h9D);
    tbl_rd[2] = mk(1'b1, {1'b0, 8'd12}, 8'h00, 1'b1, 1'b0, 8'hF9);
    tbl_rd[3] = mk(1'b1, {1'b0, 8'd63}, 8'h00, 1'b1, 1'b0, 8'hBB);
    tbl_rd[4] = mk(1'b1, {1'b0, 8'hDE}, 8'h00, CHECK_EN, 1'b1, 8'h00);
    tbl_rd[5] = mk(1'b0, {1'b0, 8'd200}, 8'h17, CHECK_EN, 1'b1, 8'h00);
    tbl_rd[6] = mk(1'b1, {1'b0, 8'd8}, 8'h00, 1'b0, 1'b0, 8'h00);

    // Reset
    PRESETn = 1'b1;
    transfer = 1'b0; READ_WRITE = 1'b0;
    apb_write_paddr = '0; apb_write_data = '0; apb_read_paddr = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    exp_rd  = 8'h00;
    check("reset_pslverr", {7'd0, PSLVERR}, 8'd0);
    check("reset_rdata", apb_read_data_out, 8'h00);

    // Fill both slaves so every later read has a known value
    for (int s = 0; s < 2; s++) begin
      for (int off = 0; off < MEM_DEPTH; off++) begin
        a = {1'(s), 8'(off)};
        pend.push_back(mk(1'b0, a, (s == 0 && off == 8) ? 8'h5A : 8'($urandom), 1'b0, 1'b0, 8'h00));
      end
    end
    run();

    // Directed writes, held back-to-back
    for (int i = 0; i < 4; i++) pend.push_back(tbl_wr[i]);
    run();

    // Make read data non-zero, then reset in SETUP with transfer still high
    pend.push_back(tbl_rd[2]);
    run();
    set_txn(mk(1'b1, {1'b0, 8'hDE}, 8'h00, 1'b0, 1'b0, 8'h00));
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    PRESETn  = 1'b0;
    transfer = 1'b0;
    exp_rd   = 8'h00;
    check("midreset_rdata", apb_read_data_out, 8'h00);
    check("midreset_pslverr", {7'd0, PSLVERR}, 8'd0);
    @(posedge PCLK); #1;
    check("postreset_pslverr", {7'd0, PSLVERR}, 8'd0);
    check("postreset_rdata", apb_read_data_out, 8'h00);

    // Retained reads, error read, error write, read-back of offset 8
    for (int i = 0; i < 7; i++) pend.push_back(tbl_rd[i]);
    run();

    // Handshake: transfer drops in ACCESS, bus must stay idle
    pend.push_back(mk(1'b0, {1'b0, 8'd5}, 8'hC3, 1'b0, 1'b0, 8'h00));
    run();
    idle(4);
    pend.push_back(mk(1'b1, {1'b1, 8'd0}, 8'h00, 1'b0, 1'b0, 8'h00));
    pend.push_back(mk(1'b1, {1'b0, 8'd5}, 8'h00, 1'b1, 1'b0, 8'hC3));
    run();

    // Randomized bursts
    for (int b = 0; b < 60; b++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        a[8]   = 1'($urandom);
        a[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255))
                                             : 8'($urandom_range(0, 63));
        pend.push_back(mk(1'($urandom), a, 8'($urandom), 1'b0, 1'b0, 8'h00));
      end
      run();
      idle($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
